// File: rtl/rgb_region_pkg.sv
// rgb_region_pkg: shared enums and geometry helper for the region filter controller
package rgb_region_pkg;
  typedef enum logic [1:0] {STATIC, DIAG, CHECKER, ROTATE} mode_e;
  typedef enum logic {SYNC_WAIT, ACTIVE} state_e;
  function automatic int sec_width(input int res, input int n);
    return res / n;
  endfunction
endpackage

// File: rtl/section_counter.sv
// section_counter: saturating position counter split into equal sections, last one absorbing the remainder
module section_counter
  import rgb_region_pkg::*;
#(
  parameter int Resolution = 1920,
  parameter int NumSections = 4,
  localparam int CW = $clog2(Resolution + 1),
  localparam int SW = $clog2(NumSections) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          cnt_en,
  input  logic          adv_en,
  output logic [CW-1:0] cnt,
  output logic [SW-1:0] sec,
  output logic          sec_edge,
  output logic          wrap
);
  localparam int W = sec_width(Resolution, NumSections);
  logic at_bnd;
  always_comb begin
    at_bnd = cnt_en && adv_en && int'(sec) < NumSections - 1 && int'(cnt) == (int'(sec) + 1) * W - 1;
    wrap = cnt_en && !clr && int'(cnt) == Resolution - 1;
  end
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      sec <= '0;
      sec_edge <= 1'b0;
    end else begin
      sec_edge <= at_bnd;
      if (at_bnd) sec <= sec + SW'(1);
      if (cnt_en && int'(cnt) != Resolution) cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/region_filt_ctrl.sv
// region_filt_ctrl: tracks X/Y frame section of the video stream and drives per-filter enables
module region_filt_ctrl
  import rgb_region_pkg::*;
#(
  parameter int XResolution = 1920,
  parameter int YResolution = 1080,
  parameter int XNumSections = 4,
  parameter int YNumSections = 4,
  parameter int NumFilters = 4,
  parameter int FramesPerStep = 60
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              valid_i,
  input  logic                              ready_i,
  input  logic                              hsync_i,
  input  logic                              vsync_i,
  input  logic                              vde_i,
  input  logic [1:0]                        mode_i,
  input  logic [NumFilters-1:0]             mask_i,
  output logic [$clog2(XNumSections):0]     x_sec_o,
  output logic [$clog2(YNumSections):0]     y_sec_o,
  output logic                              x_edge_o,
  output logic                              y_edge_o,
  output logic                              frame_start_o,
  output logic [NumFilters-1:0]             enable_o
);
  localparam int XCW = $clog2(XResolution + 1);
  localparam int YCW = $clog2(YResolution + 1);
  localparam int STW = NumFilters > 1 ? $clog2(NumFilters) : 1;
  localparam int FCW = FramesPerStep > 1 ? $clog2(FramesPerStep) : 1;
  logic beat, hs_q, vs_q, hs_rise, vs_rise, x_wrap, y_wrap, unused;
  logic [XCW-1:0] x_cnt;
  logic [YCW-1:0] y_cnt;
  logic [NumFilters-1:0] mask_q, pat;
  logic [FCW-1:0] frame_q;
  logic [STW-1:0] step_q;
  state_e state_q, state_d;
  mode_e mode_q;
  int s;
  assign beat = valid_i & ready_i;
  assign hs_rise = beat & hsync_i & ~hs_q;
  assign vs_rise = beat & vsync_i & ~vs_q;
  assign unused = ^{x_cnt, y_cnt, y_wrap};
  section_counter #(.Resolution(XResolution), .NumSections(XNumSections)) u_x (
    .clk(clk_i), .rst(rst_i), .clr(vs_rise | hs_rise), .cnt_en(beat & vde_i), .adv_en(1'b1),
    .cnt(x_cnt), .sec(x_sec_o), .sec_edge(x_edge_o), .wrap(x_wrap)
  );
  section_counter #(.Resolution(YResolution), .NumSections(YNumSections)) u_y (
    .clk(clk_i), .rst(rst_i), .clr(vs_rise), .cnt_en(x_wrap), .adv_en(1'b1),
    .cnt(y_cnt), .sec(y_sec_o), .sec_edge(y_edge_o), .wrap(y_wrap)
  );
  always_comb state_d = vs_rise ? ACTIVE : state_q;
  always_comb begin
    s = int'(x_sec_o) + int'(y_sec_o);
    pat = mode_q == STATIC  ? '1 :
          mode_q == DIAG    ? NumFilters'(1) << (s % NumFilters) :
          mode_q == CHECKER ? (s[0] ? '0 : '1) :
                              NumFilters'(1) << step_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SYNC_WAIT;
      mode_q <= STATIC;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      mask_q <= '0;
      frame_q <= '0;
      step_q <= '0;
      frame_start_o <= 1'b0;
      enable_o <= '0;
    end else begin
      state_q <= state_d;
      mask_q <= mask_i;
      frame_start_o <= vs_rise;
      enable_o <= state_q == ACTIVE ? mask_q & pat : '0;
      if (beat) begin
        hs_q <= hsync_i;
        vs_q <= vsync_i;
      end
      if (vs_rise) begin
        mode_q <= mode_e'(mode_i);
        frame_q <= (state_q == SYNC_WAIT || int'(frame_q) == FramesPerStep - 1) ? '0 : frame_q + FCW'(1);
        // step only advances on a frame-counter wrap inside ACTIVE; entering ACTIVE restarts it
        if (state_q == SYNC_WAIT) step_q <= '0;
        else if (int'(frame_q) == FramesPerStep - 1) step_q <= int'(step_q) == NumFilters - 1 ? '0 : step_q + STW'(1);
      end
    end
  end
endmodule

// File: tb/tb_region_filt_ctrl.sv
// tb_region_filt_ctrl: directed checks of section tracking, edges and enable patterns
module tb_region_filt_ctrl;
  logic clk_i, rst_i, valid_i, ready_i, hsync_i, vsync_i, vde_i;
  logic [1:0] mode_i;
  logic [3:0] mask_i;
  logic [2:0] x_sec_o;
  logic [1:0] y_sec_o;
  logic x_edge_o, y_edge_o, frame_start_o;
  logic [3:0] enable_o;
  int tests = 0;
  int fails = 0;
  region_filt_ctrl #(
    .XResolution(16), .YResolution(8), .XNumSections(4), .YNumSections(2),
    .NumFilters(4), .FramesPerStep(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_i(ready_i),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .vde_i(vde_i), .mode_i(mode_i), .mask_i(mask_i),
    .x_sec_o(x_sec_o), .y_sec_o(y_sec_o), .x_edge_o(x_edge_o), .y_edge_o(y_edge_o),
    .frame_start_o(frame_start_o), .enable_o(enable_o)
  );
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end
  task automatic do_beat(input logic h, input logic v, input logic d);
    valid_i = 1'b1; ready_i = 1'b1; hsync_i = h; vsync_i = v; vde_i = d;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask
  task automatic do_reset();
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; hsync_i = 1'b0; vsync_i = 1'b0; vde_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask
  task automatic test_reset();
    mode_i = 2'd0; mask_i = 4'hF;
    do_reset();
    tests++;
    if ({x_sec_o, y_sec_o, x_edge_o, y_edge_o, frame_start_o, enable_o} !== 12'h0) begin
      fails++; $display("FAIL reset_outputs got %h exp 000", {x_sec_o, y_sec_o, x_edge_o, y_edge_o, frame_start_o, enable_o});
    end
    for (int i = 0; i < 20; i++) begin
      do_beat(i[0], 1'b0, 1'b0);
      tests++;
      if (enable_o !== 4'h0 || frame_start_o !== 1'b0) begin
        fails++; $display("FAIL sync_wait_enable beat %0d got en=%b fs=%b exp en=0000 fs=0", i, enable_o, frame_start_o);
      end
    end
  endtask
  task automatic test_line();
    int fs_cnt, xe_cnt;
    do_reset();
    mode_i = 2'd0;
    do_beat(1'b0, 1'b1, 1'b0);
    tests++;
    if (frame_start_o !== 1'b1) begin fails++; $display("FAIL frame_start_pulse got %b exp 1", frame_start_o); end
    fs_cnt = 1; xe_cnt = 0;
    do_beat(1'b0, 1'b0, 1'b0);
    fs_cnt += int'(frame_start_o);
    do_beat(1'b1, 1'b0, 1'b0);
    fs_cnt += int'(frame_start_o);
    for (int p = 0; p < 16; p++) begin
      do_beat(1'b0, 1'b0, 1'b1);
      fs_cnt += int'(frame_start_o);
      xe_cnt += int'(x_edge_o);
      tests++;
      if (x_edge_o !== (p == 3 || p == 7 || p == 11)) begin
        fails++; $display("FAIL line_x_edge pixel %0d got %b exp %b", p, x_edge_o, (p == 3 || p == 7 || p == 11));
      end
    end
    tests++;
    if (fs_cnt != 1 || xe_cnt != 3) begin fails++; $display("FAIL line_pulse_counts got fs=%0d xe=%0d exp fs=1 xe=3", fs_cnt, xe_cnt); end
    tests++;
    if (x_sec_o !== 3'd3) begin fails++; $display("FAIL line_x_sec_end got %0d exp 3", x_sec_o); end
  endtask
  task automatic test_diag();
    int ye_cnt;
    do_reset();
    mode_i = 2'd1; mask_i = 4'hF; ye_cnt = 0;
    do_beat(1'b0, 1'b1, 1'b0);
    do_beat(1'b0, 1'b0, 1'b0);
    for (int l = 0; l < 8; l++) begin
      do_beat(1'b1, 1'b0, 1'b0);
      for (int p = 0; p < 16; p++) begin
        do_beat(1'b0, 1'b0, 1'b1);
        ye_cnt += int'(y_edge_o);
        tests++;
        if (y_edge_o !== (l == 3 && p == 15)) begin
          fails++; $display("FAIL diag_y_edge line %0d pixel %0d got %b exp %b", l, p, y_edge_o, (l == 3 && p == 15));
        end
        if (l == 0 && p == 1) begin
          tests++;
          if (enable_o !== 4'b0001) begin fails++; $display("FAIL diag_s0 got %b exp 0001", enable_o); end
        end
        if (l == 0 && p == 9) begin
          tests++;
          if (enable_o !== 4'b0100) begin fails++; $display("FAIL diag_x2y0 got %b exp 0100", enable_o); end
        end
        if (l == 4 && p == 9) begin
          tests++;
          if (enable_o !== 4'b1000 || y_sec_o !== 2'd1) begin fails++; $display("FAIL diag_x2y1 got en=%b y=%0d exp en=1000 y=1", enable_o, y_sec_o); end
        end
        if (l == 4 && p == 13) begin
          tests++;
          if (enable_o !== 4'b0001) begin fails++; $display("FAIL diag_x3y1 got %b exp 0001", enable_o); end
        end
      end
    end
    tests++;
    if (ye_cnt != 1) begin fails++; $display("FAIL diag_y_edge_count got %0d exp 1", ye_cnt); end
  endtask
  task automatic test_rotate();
    logic [3:0] exp_en [5] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100};
    do_reset();
    mode_i = 2'd3; mask_i = 4'hF;
    for (int f = 0; f < 5; f++) begin
      do_beat(1'b0, 1'b1, 1'b0);
      do_beat(1'b0, 1'b0, 1'b0);
      do_beat(1'b0, 1'b0, 1'b0);
      tests++;
      if (enable_o !== exp_en[f]) begin fails++; $display("FAIL rotate_frame %0d got %b exp %b", f, enable_o, exp_en[f]); end
    end
  endtask
  task automatic test_stall_mode();
    do_reset();
    mode_i = 2'd1; mask_i = 4'hF;
    do_beat(1'b0, 1'b1, 1'b0);
    do_beat(1'b0, 1'b0, 1'b0);
    do_beat(1'b1, 1'b0, 1'b0);
    for (int p = 0; p < 5; p++) do_beat(1'b0, 1'b0, 1'b1);
    tests++;
    if (x_sec_o !== 3'd1 || enable_o !== 4'b0010) begin fails++; $display("FAIL stall_pre got x=%0d en=%b exp x=1 en=0010", x_sec_o, enable_o); end
    mode_i = 2'd2;
    valid_i = 1'b1; ready_i = 1'b0; vde_i = 1'b1; hsync_i = 1'b0; vsync_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      tests++;
      if (x_sec_o !== 3'd1 || x_edge_o !== 1'b0) begin fails++; $display("FAIL stall_hold cycle %0d got x=%0d edge=%b exp x=1 edge=0", i, x_sec_o, x_edge_o); end
    end
    valid_i = 1'b0; ready_i = 1'b1;
    tests++;
    if (enable_o !== 4'b0010) begin fails++; $display("FAIL mode_midframe got %b exp 0010", enable_o); end
    for (int p = 5; p < 8; p++) begin
      do_beat(1'b0, 1'b0, 1'b1);
      tests++;
      if (x_edge_o !== (p == 7)) begin fails++; $display("FAIL stall_resume pixel %0d got %b exp %b", p, x_edge_o, (p == 7)); end
    end
    tests++;
    if (x_sec_o !== 3'd2) begin fails++; $display("FAIL stall_x_sec got %0d exp 2", x_sec_o); end
    do_beat(1'b0, 1'b1, 1'b0);
    tests++;
    if (frame_start_o !== 1'b1 || x_sec_o !== 3'd0) begin fails++; $display("FAIL new_frame got fs=%b x=%0d exp fs=1 x=0", frame_start_o, x_sec_o); end
    do_beat(1'b0, 1'b0, 1'b0);
    tests++;
    if (enable_o !== 4'hF) begin fails++; $display("FAIL checker_even got %b exp 1111", enable_o); end
    do_beat(1'b1, 1'b0, 1'b0);
    for (int p = 0; p < 6; p++) do_beat(1'b0, 1'b0, 1'b1);
    tests++;
    if (enable_o !== 4'h0) begin fails++; $display("FAIL checker_odd got %b exp 0000", enable_o); end
  endtask
  task automatic test_mid_reset();
    do_reset();
    mode_i = 2'd0; mask_i = 4'b0101;
    do_beat(1'b0, 1'b1, 1'b0);
    do_beat(1'b0, 1'b0, 1'b0);
    tests++;
    if (enable_o !== 4'b0101) begin fails++; $display("FAIL mask_static got %b exp 0101", enable_o); end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    tests++;
    if (enable_o !== 4'h0 || x_sec_o !== 3'd0 || frame_start_o !== 1'b0) begin
      fails++; $display("FAIL mid_reset got en=%b x=%0d fs=%b exp en=0000 x=0 fs=0", enable_o, x_sec_o, frame_start_o);
    end
    do_beat(1'b1, 1'b0, 1'b0);
    for (int p = 0; p < 5; p++) do_beat(1'b0, 1'b0, 1'b1);
    tests++;
    if (enable_o !== 4'h0 || x_sec_o !== 3'd1) begin fails++; $display("FAIL post_reset_wait got en=%b x=%0d exp en=0000 x=1", enable_o, x_sec_o); end
    do_beat(1'b0, 1'b1, 1'b0);
    do_beat(1'b0, 1'b0, 1'b0);
    tests++;
    if (enable_o !== 4'b0101) begin fails++; $display("FAIL post_reset_active got %b exp 0101", enable_o); end
  endtask
  task automatic test_saturate();
    int xe_cnt;
    do_reset();
    mode_i = 2'd0; mask_i = 4'hF; xe_cnt = 0;
    do_beat(1'b0, 1'b1, 1'b0);
    do_beat(1'b0, 1'b0, 1'b0);
    do_beat(1'b1, 1'b0, 1'b0);
    for (int p = 0; p < 20; p++) begin
      do_beat(1'b0, 1'b0, 1'b1);
      xe_cnt += int'(x_edge_o);
      tests++;
      if (x_edge_o !== (p == 3 || p == 7 || p == 11)) begin
        fails++; $display("FAIL sat_x_edge pixel %0d got %b exp %b", p, x_edge_o, (p == 3 || p == 7 || p == 11));
      end
    end
    tests++;
    if (x_sec_o !== 3'd3 || xe_cnt != 3) begin fails++; $display("FAIL sat_end got x=%0d edges=%0d exp x=3 edges=3", x_sec_o, xe_cnt); end
    for (int l = 1; l < 4; l++) begin
      do_beat(1'b1, 1'b0, 1'b0);
      tests++;
      if (x_sec_o !== 3'd0 || x_edge_o !== 1'b0) begin fails++; $display("FAIL hsync_clear line %0d got x=%0d edge=%b exp x=0 edge=0", l, x_sec_o, x_edge_o); end
      for (int p = 0; p < 16; p++) do_beat(1'b0, 1'b0, 1'b1);
    end
    tests++;
    if (y_sec_o !== 2'd1) begin fails++; $display("FAIL sat_y_sec got %0d exp 1", y_sec_o); end
    do_beat(1'b1, 1'b1, 1'b0);
    tests++;
    if (frame_start_o !== 1'b1 || x_edge_o !== 1'b0 || y_edge_o !== 1'b0 || x_sec_o !== 3'd0 || y_sec_o !== 2'd0) begin
      fails++; $display("FAIL vsync_hsync_same got fs=%b xe=%b ye=%b x=%0d y=%0d exp fs=1 xe=0 ye=0 x=0 y=0",
                        frame_start_o, x_edge_o, y_edge_o, x_sec_o, y_sec_o);
    end
  endtask
  initial begin
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; hsync_i = 1'b0; vsync_i = 1'b0; vde_i = 1'b0;
    mode_i = 2'd0; mask_i = 4'hF;
    @(posedge clk_i); #1;
    test_reset();
    test_line();
    test_diag();
    test_rotate();
    test_stall_mode();
    test_mid_reset();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/region_filt_ctrl.md
# region_filt_ctrl

Parametrised frame-geometry tracker and filter-enable generator for the RGB processing path. It sits beside the video filter pipeline and observes the same input stream (valid/ready, hsync, vsync, vde). It tracks the current pixel's X/Y section on an XNumSections × YNumSections grid and drives the per-filter enable vector of the pipeline. It supersedes the fixed 4×4 x/y counter pair and FSM, adding a configurable grid size, filter count and runtime-selectable spatial/temporal enable modes.

## Interface
- XResolution, 1920, active pixels per line
- YResolution, 1080, active lines per frame
- XNumSections, 4, horizontal sections, ≥1, ≤ XResolution
- YNumSections, 4, vertical sections, ≥1, ≤ YResolution
- NumFilters, 4, width of enable vector, ≥1
- FramesPerStep, 60, frames per ROTATE step, ≥1

- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, reset synchronous and active-high
- valid_i  in  1  input-stream valid
- ready_i  in  1  input-stream ready (pipeline ready_o)
- hsync_i  in  1  horizontal sync of the input stream
- vsync_i  in  1  vertical sync of the input stream
- vde_i  in  1  active-video flag of the input stream
- mode_i  in  2  enable mode: 0 STATIC, 1 DIAG, 2 CHECKER, 3 ROTATE
- mask_i  in  NumFilters  filters allowed to be enabled
- x_sec_o  out  $clog2(XNumSections)+1  current X section
- y_sec_o  out  $clog2(YNumSections)+1  current Y section
- x_edge_o  out  1  one-cycle pulse on X section change
- y_edge_o  out  1  one-cycle pulse on Y section change
- frame_start_o  out  1  one-cycle pulse on vsync rising edge
- enable_o  out  NumFilters  filter enables to the pipeline

## Operation
- Beat = valid_i & ready_i. hsync_i, vsync_i and vde_i are sampled only on beats. Sync edges are detected against the previous beat's value.
- Section width: XW = XResolution / XNumSections (integer division). The last section absorbs the remainder. Y is the same with YW.
- X: a vde beat increments x_cnt. When x_cnt reaches k·XW−1 with x_sec < XNumSections−1, x_sec increments and x_edge_o pulses. x_cnt saturates at XResolution. Pixels past the resolution produce no further edges.
- hsync rising beat: x_cnt=0, x_sec=0, no x_edge_o.
- Y: a line completes when a vde beat hits x_cnt = XResolution−1. Y then advances by the same rules using YW and y_edge_o, saturating at YResolution.
- vsync rising beat: x and y cleared, frame_start_o pulses, frame counter advances, mode_i is latched into a shadow register. Changes to mode_i mid-frame have no effect.
- FSM states:
  - SYNC_WAIT: reset state. enable_o forced 0. Moves to ACTIVE on the first vsync rising beat.
  - ACTIVE: enable_o = mask_i & pattern.
- Patterns (s = x_sec + y_sec):
  - STATIC: all ones.
  - DIAG: onehot(s mod NumFilters).
  - CHECKER: all ones if s is even, else 0.
  - ROTATE: onehot(step). step increments mod NumFilters every FramesPerStep frame starts.
- Frame counter and step reset to 0 when they wrap, and also on entering ACTIVE.

## Timing
- All outputs are registered. Reset value of every output is 0. Shadow mode resets to STATIC; state resets to SYNC_WAIT.
- Edges and frame_start_o pulse in the cycle after the causing beat. Sections update in the same cycle as their edge.
- enable_o reflects the new section or step one cycle after x_sec_o/y_sec_o change, i.e. two cycles after the beat.
- mask_i is registered, 1-cycle latency.
- No beat means no state change. Stalls (valid_i=1, ready_i=0) never count.
- Simultaneous vsync and hsync rising beat: the vsync action wins (superset). Only frame_start_o pulses; no edges.
- rst_i mid-frame: everything clears next cycle. Enables stay 0 until the next vsync rising beat.

## Structure
- Package rgb_region_pkg: mode_e enum (STATIC, DIAG, CHECKER, ROTATE), state_e enum (SYNC_WAIT, ACTIVE), and a function computing section width.
- One sub-module, section_counter (params Resolution, NumSections). It has inputs for clear, count and boundary-advance, and outputs cnt, sec, edge and wrap. It is instantiated twice: X driven by vde beats, Y driven by X line completion.

## Test plan
Parameters for all scenarios: XRes=16, YRes=8, XSec=4, YSec=2, NumFilters=4, FramesPerStep=2.
- Reset, 20 beats with no vsync, mask=4'hF -> enable_o stays 0, state SYNC_WAIT, all outputs 0.
- vsync pulse then one 16-pixel line -> frame_start_o once; x_edge_o after pixels 3, 7 and 11 (3 pulses); x_sec_o ends at 3.
- DIAG, full frame -> y_edge_o once after line 3. At x_sec=2, y_sec=1, enable_o=4'b1000; at x_sec=3, y_sec=1, enable_o=4'b0001.
- ROTATE over 5 frames -> enable_o steps 0001, 0001, 0010, 0010, 0100 per frame.
- ready_i held low for 10 cycles with valid_i=1 mid-line -> no x_cnt change. Changing mode_i mid-frame leaves the pattern unchanged until the next frame_start_o.
- 20 vde beats on one line without hsync -> x_sec_o saturates at 3 with no extra edges. An hsync beat then returns x_sec_o to 0.
